// File: rtl/rv32imc_3p_pkg.sv
// Shared definitions for the 3-port writeback block.
//   XLEN_DEFAULT / NREG_DEFAULT : default data width / tracked register count
//   reg_addr_t                  : 5-bit architectural register address
//   wb_src_e                    : writeback source selector
package rv32imc_3p_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 16;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;
endpackage

// File: rtl/rv32imc_3p_scoreboard.sv
// Pending-register scoreboard.
//   clk, rst_n           : clock, synchronous active-low reset
//   set_en, set_addr     : mark a destination pending (wins over a same-cycle clear)
//   clr_en, clr_addr     : clear on an accepted LSU/MDU writeback
//   rs1_addr, rs2_addr   : decode source lookup
//   rs_hazard            : a nonzero source is pending
// Register 0 and addresses >= NREG are never pending.
module rv32imc_3p_scoreboard
  import rv32imc_3p_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs_hazard
);
  // bit 0 does not exist: x0 is never pending
  logic [NREG-1:1] pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (set_en && set_addr == 5'(i))      pend[i] <= 1'b1;
        else if (clr_en && clr_addr == 5'(i)) pend[i] <= 1'b0;
      end
    end
  end

  // match against real indices only, so out-of-range addresses read 0
  always_comb begin
    rs_hazard = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (pend[i] && (rs1_addr == 5'(i) || rs2_addr == 5'(i))) rs_hazard = 1'b1;
    end
  end
endmodule

// File: rtl/rv32imc_3p_wb.sv
// Writeback arbiter with pending-register scoreboard.
// Sources in fixed priority ALU > LSU > MDU; one transfer per cycle is
// registered onto the register-file write port with latency 1.
//   clk, rst_n                      : clock, synchronous active-low reset
//   alu_valid/rd/dat                : ALU result (always wins, no ready)
//   lsu_valid/ready/rd/dat          : load result handshake
//   mdu_valid/ready/rd/dat          : mul/div result handshake (macro build only)
//   sb_set, sb_set_addr             : mark long-latency destination pending
//   rs1_addr, rs2_addr, rs_hazard   : decode hazard lookup
//   c_rf_write, rd_addr, rd_dati    : register-file write port
// Macro RV32IMC_3P_WB_MDU_EN: present MDU ports and arbitrate three sources;
// undefined leaves a two-source arbiter and only LSU clears pending bits.
module rv32imc_3p_wb
  import rv32imc_3p_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_dat,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_dat,
`ifdef RV32IMC_3P_WB_MDU_EN
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_dat,
`endif
  input  logic            sb_set,
  input  logic [4:0]      sb_set_addr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs_hazard,
  output logic            c_rf_write,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_dati
);
  wb_src_e         src;
  logic            xfer;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_dat;
  logic            clr_en;

  always_comb begin
    src     = WB_ALU;
    xfer    = 1'b0;
    sel_rd  = '0;
    sel_dat = '0;
    if (alu_valid) begin
      xfer = 1'b1; src = WB_ALU; sel_rd = alu_rd; sel_dat = alu_dat;
    end else if (lsu_valid) begin
      xfer = 1'b1; src = WB_LSU; sel_rd = lsu_rd; sel_dat = lsu_dat;
    end
`ifdef RV32IMC_3P_WB_MDU_EN
    else if (mdu_valid) begin
      xfer = 1'b1; src = WB_MDU; sel_rd = mdu_rd; sel_dat = mdu_dat;
    end
`endif
  end

  // ready is gated by reset so nothing handshakes while the block is held
  assign lsu_ready = rst_n & lsu_valid & ~alu_valid;
`ifdef RV32IMC_3P_WB_MDU_EN
  assign mdu_ready = rst_n & mdu_valid & ~alu_valid & ~lsu_valid;
`endif

  // only long-latency sources retire a pending bit
  assign clr_en = rst_n & xfer & (src != WB_ALU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_rf_write <= 1'b0;
      rd_addr    <= '0;
      rd_dati    <= '0;
    end else begin
      // rd=0 is consumed but never written
      c_rf_write <= xfer && (sel_rd != '0);
      if (xfer) begin
        rd_addr <= sel_rd;
        rd_dati <= sel_dat;
      end
    end
  end

  rv32imc_3p_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set),
    .set_addr  (sb_set_addr),
    .clr_en    (clr_en),
    .clr_addr  (sel_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs_hazard (rs_hazard)
  );
endmodule

// File: tb/tb_rv32imc_3p_wb.sv
module tb_rv32imc_3p_wb;
  localparam int XLEN = 32;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid, sb_set;
  logic [4:0]      alu_rd, lsu_rd, sb_set_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] alu_dat, lsu_dat;
  logic            lsu_ready, rs_hazard, c_rf_write;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_dati;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_dat;
`ifdef RV32IMC_3P_WB_MDU_EN
  logic            mdu_ready;
  localparam bit   HAS_MDU = 1'b1;
`else
  localparam bit   HAS_MDU = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv32imc_3p_wb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_dat(alu_dat),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_dat(lsu_dat),
`ifdef RV32IMC_3P_WB_MDU_EN
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_dat(mdu_dat),
`endif
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_hazard(rs_hazard),
    .c_rf_write(c_rf_write), .rd_addr(rd_addr), .rd_dati(rd_dati)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit [NREG-1:0]   pm;       // pending set, indexed by register number
  bit              m_we;
  bit [4:0]        m_rd;
  bit [XLEN-1:0]   m_dat;
  bit              m_live = 0;

  function automatic bit is_pend(input bit [4:0] a);
    return (a != 0) && (a < NREG) && pm[a[3:0]];
  endfunction

  always @(posedge clk) begin
    bit [4:0]      w_rd;
    bit [XLEN-1:0] w_dat;
    bit            got, lng;
    got = 0; lng = 0; w_rd = 0; w_dat = 0;
    if (!rst_n) begin
      pm = '0; m_we = 0; m_rd = 0; m_dat = 0; m_live = 1;
    end else begin
      if (alu_valid)                   begin got = 1; w_rd = alu_rd; w_dat = alu_dat; end
      else if (lsu_valid)              begin got = 1; lng = 1; w_rd = lsu_rd; w_dat = lsu_dat; end
      else if (HAS_MDU && mdu_valid)   begin got = 1; lng = 1; w_rd = mdu_rd; w_dat = mdu_dat; end
      m_we = got && (w_rd != 0);
      if (got) begin m_rd = w_rd; m_dat = w_dat; end
      if (lng && w_rd != 0 && w_rd < NREG) pm[w_rd[3:0]] = 1'b0;
      if (sb_set && sb_set_addr != 0 && sb_set_addr < NREG) pm[sb_set_addr[3:0]] = 1'b1;
    end
  end

  // every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_we", {31'd0, c_rf_write}, {31'd0, m_we});
      if (m_we) begin
        chk("m_rd", {27'd0, rd_addr}, {27'd0, m_rd});
        chk("m_dat", rd_dati, m_dat);
      end
      chk("m_lsu_ready", {31'd0, lsu_ready}, {31'd0, rst_n && lsu_valid && !alu_valid});
`ifdef RV32IMC_3P_WB_MDU_EN
      chk("m_mdu_ready", {31'd0, mdu_ready},
          {31'd0, rst_n && mdu_valid && !alu_valid && !lsu_valid});
`endif
      chk("m_hazard", {31'd0, rs_hazard}, {31'd0, is_pend(rs1_addr) || is_pend(rs2_addr)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0; sb_set = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    alu_rd = 0; alu_dat = 0; lsu_rd = 0; lsu_dat = 0; mdu_rd = 0; mdu_dat = 0;
    sb_set_addr = 0; rs1_addr = 0; rs2_addr = 0;
    lsu_valid = 1; lsu_rd = 4; mdu_valid = 1;
    step(); step();
    chk("rst_we", {31'd0, c_rf_write}, 32'd0);
    chk("rst_rd", {27'd0, rd_addr}, 32'd0);
    chk("rst_dat", rd_dati, 32'd0);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    idle(); rst_n = 1;
    step();

    // ALU x5 = 0x1234
    alu_valid = 1; alu_rd = 5; alu_dat = 32'h1234;
    step();
    chk("alu_we", {31'd0, c_rf_write}, 32'd1);
    chk("alu_rd", {27'd0, rd_addr}, 32'd5);
    chk("alu_dat", rd_dati, 32'h1234);
    idle();
    step();
    chk("alu_we_off", {31'd0, c_rf_write}, 32'd0);

    // three-way contention, ALU drops after cycle 1
    alu_valid = 1; alu_rd = 1; alu_dat = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_dat = 32'h22;
    mdu_valid = 1; mdu_rd = 3; mdu_dat = 32'h33;
    #1 chk("c1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    step();
    chk("c1_rd", {27'd0, rd_addr}, 32'd1);
    alu_valid = 0;
    #1 chk("c2_lsu_ready", {31'd0, lsu_ready}, 32'd1);
`ifdef RV32IMC_3P_WB_MDU_EN
    chk("c2_mdu_ready", {31'd0, mdu_ready}, 32'd0);
`endif
    step();
    chk("c2_we", {31'd0, c_rf_write}, 32'd1);
    chk("c2_rd", {27'd0, rd_addr}, 32'd2);
    chk("c2_dat", rd_dati, 32'h22);
    lsu_valid = 0;
`ifdef RV32IMC_3P_WB_MDU_EN
    #1 chk("c3_mdu_ready", {31'd0, mdu_ready}, 32'd1);
`endif
    step();
`ifdef RV32IMC_3P_WB_MDU_EN
    chk("c3_rd", {27'd0, rd_addr}, 32'd3);
    chk("c3_dat", rd_dati, 32'h33);
`else
    chk("c3_we", {31'd0, c_rf_write}, 32'd0);
`endif
    idle();
    step();

    // scoreboard x7 then LSU return
    sb_set = 1; sb_set_addr = 7;
    step();
    sb_set = 0; rs1_addr = 7;
    #1 chk("x7_hazard", {31'd0, rs_hazard}, 32'd1);
    lsu_valid = 1; lsu_rd = 7; lsu_dat = 32'hCAFE;
    #1 chk("x7_ready", {31'd0, lsu_ready}, 32'd1);
    step();
    chk("x7_hazard_clr", {31'd0, rs_hazard}, 32'd0);
    chk("x7_we", {31'd0, c_rf_write}, 32'd1);
    chk("x7_rd", {27'd0, rd_addr}, 32'd7);
    chk("x7_dat", rd_dati, 32'hCAFE);
    idle(); rs1_addr = 0;
    step();

    // set and clear of x9 in the same cycle: set wins
    sb_set = 1; sb_set_addr = 9;
`ifdef RV32IMC_3P_WB_MDU_EN
    mdu_valid = 1; mdu_rd = 9; mdu_dat = 32'h99;
`else
    lsu_valid = 1; lsu_rd = 9; lsu_dat = 32'h99;
`endif
    step();
    idle(); rs2_addr = 9;
    #1 chk("x9_set_wins", {31'd0, rs_hazard}, 32'd1);
    // ALU write does not clear; re-set is harmless; out-of-range set ignored
    alu_valid = 1; alu_rd = 9; alu_dat = 32'h5;
    sb_set = 1; sb_set_addr = 9;
    step();
    sb_set = 1; sb_set_addr = 20; alu_valid = 0;
    step();
    idle(); rs1_addr = 20;
    #1 chk("x9_alu_keeps", {31'd0, rs_hazard}, 32'd1);
    rs2_addr = 0;
    #1 chk("x20_ignored", {31'd0, rs_hazard}, 32'd0);
    rs2_addr = 9; lsu_valid = 1; lsu_rd = 9; lsu_dat = 32'h9A;
    step();
    idle();
    #1 chk("x9_cleared", {31'd0, rs_hazard}, 32'd0);
    rs1_addr = 0; rs2_addr = 0;

    // LSU return to x0
    lsu_valid = 1; lsu_rd = 0; lsu_dat = 32'hFFFF;
    #1 chk("x0_ready", {31'd0, lsu_ready}, 32'd1);
    step();
    chk("x0_we", {31'd0, c_rf_write}, 32'd0);
    idle();
    step();

    // reset with x3 pending and an output valid
    sb_set = 1; sb_set_addr = 3;
    step();
    sb_set = 0; alu_valid = 1; alu_rd = 4; alu_dat = 32'h44; rs1_addr = 3;
    step();
    chk("pre_rst_we", {31'd0, c_rf_write}, 32'd1);
    chk("pre_rst_hazard", {31'd0, rs_hazard}, 32'd1);
    rst_n = 0;
    step();
    chk("post_rst_we", {31'd0, c_rf_write}, 32'd0);
    chk("post_rst_hazard", {31'd0, rs_hazard}, 32'd0);
    idle(); rst_n = 1;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
